// File: rtl/rf_arb_pkg.sv
// Shared encodings and defaults for the register-file access arbiter.
package rf_arb_pkg;

    localparam int unsigned DEF_DW      = 16;
    localparam int unsigned DEF_AW      = 3;
    localparam int unsigned DEF_ALU_LAT = 1;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_RMW   = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WB   = 3'd3,
        ST_RSP  = 3'd4,
        ST_CLR  = 3'd5
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer flips to the loser on every accept.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       en,
    output logic [1:0] grant
);

    logic rr;

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = rr ? 2'b10 : 2'b01;
        end
    end

    // After granting req0 the next tie goes to req1, and vice versa.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr <= 1'b0;
        end else if (en && (valid != 2'b00)) begin
            rr <= grant[0];
        end
    end

endmodule

// File: rtl/rf_access_arbiter.sv
// Sequences READ/WRITE/RMW accesses from two requesters onto an 8x16 register
// file, plus a clear sequence that zeroes every register.
module rf_access_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned ALU_LAT = DEF_ALU_LAT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [3:0]      req_op,
    input  logic [2*AW-1:0] req_wadr,
    input  logic [2*AW-1:0] req_radr,
    input  logic [2*AW-1:0] req_sadr,
    input  logic [2*DW-1:0] req_wdata,
    output logic [1:0]      rsp_valid,
    output logic [DW-1:0]   rsp_r,
    output logic [DW-1:0]   rsp_s,
    output logic [AW-1:0]   rf_w_adr,
    output logic            rf_we,
    output logic [AW-1:0]   rf_r_adr,
    output logic [AW-1:0]   rf_s_adr,
    output logic [DW-1:0]   rf_w,
    input  logic [DW-1:0]   rf_r,
    input  logic [DW-1:0]   rf_s,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    input  logic [DW-1:0]   alu_y,
    input  logic            clr_req,
    output logic            clr_busy
);

    localparam int unsigned WAIT_INIT = (ALU_LAT > 1) ? ALU_LAT - 2 : 0;

    state_e          state;
    op_e             op_q;
    logic            g_q;
    logic [AW-1:0]   wadr_q;
    logic [DW-1:0]   wdata_q;
    logic [1:0]      wait_cnt;
    logic [AW-1:0]   clr_cnt;

    logic            ready_en;
    logic [1:0]      grant;
    logic            acc_g;
    op_e             acc_op;
    logic [AW-1:0]   acc_wadr;
    logic [AW-1:0]   acc_radr;
    logic [AW-1:0]   acc_sadr;
    logic [DW-1:0]   acc_wdata;

    // Accepts only in IDLE with no pending clear; reset gates it so every output reads 0.
    assign ready_en  = (state == ST_IDLE) && !clr_req && reset;
    assign req_ready = ready_en ? grant : 2'b00;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .valid (req_valid),
        .en    (ready_en),
        .grant (grant)
    );

    assign acc_g     = grant[1];
    assign acc_op    = op_e'(acc_g ? req_op[3:2] : req_op[1:0]);
    assign acc_wadr  = acc_g ? req_wadr[2*AW-1:AW]  : req_wadr[AW-1:0];
    assign acc_radr  = acc_g ? req_radr[2*AW-1:AW]  : req_radr[AW-1:0];
    assign acc_sadr  = acc_g ? req_sadr[2*AW-1:AW]  : req_sadr[AW-1:0];
    assign acc_wdata = acc_g ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];

    // ALU result is only valid in the WB cycle itself, so it cannot be pre-registered.
    assign rf_w = (state == ST_WB) ? ((op_q == OP_RMW) ? alu_y : wdata_q) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_READ;
            g_q       <= 1'b0;
            wadr_q    <= '0;
            wdata_q   <= '0;
            wait_cnt  <= 2'd0;
            clr_cnt   <= '0;
            rsp_valid <= 2'b00;
            rsp_r     <= '0;
            rsp_s     <= '0;
            rf_w_adr  <= '0;
            rf_we     <= 1'b0;
            rf_r_adr  <= '0;
            rf_s_adr  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            clr_busy  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state    <= ST_CLR;
                        rf_we    <= 1'b1;
                        rf_w_adr <= '0;
                        clr_cnt  <= '0;
                        clr_busy <= 1'b1;
                    end else if (req_ready != 2'b00) begin
                        g_q     <= acc_g;
                        op_q    <= acc_op;
                        wadr_q  <= acc_wadr;
                        wdata_q <= acc_wdata;
                        unique case (acc_op)
                            OP_READ, OP_RMW: begin
                                state    <= ST_RD;
                                rf_r_adr <= acc_radr;
                                rf_s_adr <= acc_sadr;
                            end
                            OP_WRITE: begin
                                state    <= ST_WB;
                                rf_we    <= 1'b1;
                                rf_w_adr <= acc_wadr;
                            end
                            default: begin
                                state     <= ST_RSP;
                                rsp_valid <= {acc_g, ~acc_g};
                                rsp_r     <= '0;
                                rsp_s     <= '0;
                            end
                        endcase
                    end
                end
                ST_RD: begin
                    rf_r_adr <= '0;
                    rf_s_adr <= '0;
                    if (op_q == OP_RMW) begin
                        alu_a <= rf_r;
                        alu_b <= rf_s;
                        if (ALU_LAT == 1) begin
                            state    <= ST_WB;
                            rf_we    <= 1'b1;
                            rf_w_adr <= wadr_q;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= 2'(WAIT_INIT);
                        end
                    end else begin
                        state     <= ST_RSP;
                        rsp_r     <= rf_r;
                        rsp_s     <= rf_s;
                        rsp_valid <= {g_q, ~g_q};
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state    <= ST_WB;
                        rf_we    <= 1'b1;
                        rf_w_adr <= wadr_q;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                ST_WB: begin
                    state     <= ST_RSP;
                    rf_we     <= 1'b0;
                    rf_w_adr  <= '0;
                    rsp_r     <= rf_w;
                    rsp_s     <= '0;
                    rsp_valid <= {g_q, ~g_q};
                end
                ST_RSP: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 2'b00;
                end
                ST_CLR: begin
                    if (clr_cnt == '1) begin
                        state    <= ST_IDLE;
                        rf_we    <= 1'b0;
                        rf_w_adr <= '0;
                        clr_busy <= 1'b0;
                    end else begin
                        clr_cnt  <= clr_cnt + AW'(1);
                        rf_w_adr <= clr_cnt + AW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter with a register-file model, a delayed
// adder ALU and a response scoreboard.
module tb_rf_access_arbiter;

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 3;
    localparam int unsigned LAT = 3;

    logic            clk;
    logic            reset;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [3:0]      req_op;
    logic [2*AW-1:0] req_wadr, req_radr, req_sadr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_r, rsp_s;
    logic [AW-1:0]   rf_w_adr, rf_r_adr, rf_s_adr;
    logic            rf_we;
    logic [DW-1:0]   rf_w, rf_r, rf_s;
    logic [DW-1:0]   alu_a, alu_b, alu_y;
    logic            clr_req;
    logic            clr_busy;

    typedef struct {
        logic [1:0]    v;
        logic [DW-1:0] r;
        logic [DW-1:0] s;
    } rsp_t;

    rsp_t          sb[$];
    rsp_t          mon_e;
    logic [DW-1:0] model [8];
    logic [DW-1:0] rf_mem [8] = '{default: 16'h0};
    logic [DW-1:0] alu_p0 = '0;
    logic [DW-1:0] alu_p1 = '0;
    int            errors = 0;
    int            checks = 0;

    rf_access_arbiter #(.DW(DW), .AW(AW), .ALU_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_wadr  (req_wadr),
        .req_radr  (req_radr),
        .req_sadr  (req_sadr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_r     (rsp_r),
        .rsp_s     (rsp_s),
        .rf_w_adr  (rf_w_adr),
        .rf_we     (rf_we),
        .rf_r_adr  (rf_r_adr),
        .rf_s_adr  (rf_s_adr),
        .rf_w      (rf_w),
        .rf_r      (rf_r),
        .rf_s      (rf_s),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file with combinational reads
    always @(posedge clk) if (rf_we) rf_mem[rf_w_adr] <= rf_w;
    assign rf_r = rf_mem[rf_r_adr];
    assign rf_s = rf_mem[rf_s_adr];

    // Adder whose result appears LAT cycles after operand capture
    always @(posedge clk) begin
        alu_p0 <= alu_a + alu_b;
        alu_p1 <= alu_p0;
    end
    assign alu_y = alu_p1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] onehot(input int g);
        return (g == 0) ? 2'b01 : 2'b10;
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1 && rsp_valid !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(mon_e.v));
                chk("rsp_r", 32'(rsp_r), 32'(mon_e.r));
                chk("rsp_s", 32'(rsp_s), 32'(mon_e.s));
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp"}, {14'd0, rsp_valid, rsp_r}, 32'd0);
        chk({tag, "_rsps"}, 32'(rsp_s), 32'd0);
        chk({tag, "_we"}, {rf_we, clr_busy, 6'd0, rf_w_adr, rf_r_adr, rf_s_adr, 7'd0}, 32'd0);
        chk({tag, "_w"}, 32'(rf_w), 32'd0);
        chk({tag, "_alu"}, {alu_a, alu_b}, 32'd0);
    endtask

    // Drive one request, wait for its accept, queue the expected response and update the model.
    task automatic issue(input int g, input logic [1:0] op, input logic [2:0] wa,
                         input logic [2:0] ra, input logic [2:0] sa,
                         input logic [15:0] wd, input bit expect_rsp);
        rsp_t e;
        int   n;
        req_op[2*g +: 2]     = op;
        req_wadr[3*g +: 3]   = wa;
        req_radr[3*g +: 3]   = ra;
        req_sadr[3*g +: 3]   = sa;
        req_wdata[16*g +: 16] = wd;
        req_valid[g]         = 1'b1;
        #1;
        n = 0;
        while (req_ready[g] !== 1'b1 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_ready", 32'(req_ready), 32'(onehot(g)));
        e.v = onehot(g);
        case (op)
            2'b00: begin e.r = model[ra]; e.s = model[sa]; end
            2'b01: begin e.r = wd; e.s = '0; end
            2'b10: begin e.r = model[ra] + model[sa]; e.s = '0; end
            default: begin e.r = '0; e.s = '0; end
        endcase
        if (expect_rsp) begin
            sb.push_back(e);
            if (op == 2'b01 || op == 2'b10) model[wa] = e.r;
        end
        @(negedge clk);
        req_valid[g] = 1'b0;
    endtask

    initial begin
        rsp_t e;
        int   n;
        for (int i = 0; i < 8; i++) model[i] = '0;
        reset = 1'b0; clr_req = 1'b0; req_valid = 2'b00; req_op = 4'hF;
        req_wadr = '0; req_radr = '0; req_sadr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // WRITE from req0
        issue(0, 2'b01, 3'd3, 3'd0, 3'd0, 16'hBEEF, 1'b1);
        chk("wr_we", 32'(rf_we), 32'd1);
        chk("wr_adr", 32'(rf_w_adr), 32'd3);
        chk("wr_data", 32'(rf_w), 32'hBEEF);
        @(negedge clk);
        chk("wr_rsp_t2", 32'(rsp_valid), 32'b01);
        chk("wr_we_off", 32'(rf_we), 32'd0);
        @(negedge clk);

        // READ from req1
        issue(1, 2'b00, 3'd0, 3'd3, 3'd0, 16'h0, 1'b1);
        chk("rd_radr", 32'(rf_r_adr), 32'd3);
        chk("rd_we", 32'(rf_we), 32'd0);
        @(negedge clk);
        chk("rd_rsp_t2", 32'(rsp_valid), 32'b10);
        @(negedge clk);
        chk("idle_radr", 32'(rf_r_adr), 32'd0);

        // NOP responds one cycle after accept with zeros
        issue(1, 2'b11, 3'd0, 3'd0, 3'd0, 16'h0, 1'b1);
        chk("nop_rsp_t1", 32'(rsp_valid), 32'b10);
        @(negedge clk);

        // Both requesters valid: grants alternate starting with req0
        req_op = 4'b0000;
        req_radr = {3'd1, 3'd3};
        req_sadr = {3'd3, 3'd1};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int gk;
            gk = k % 2;
            #1;
            n = 0;
            while (req_ready === 2'b00 && n < 10) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("alt_grant", 32'(req_ready), 32'(onehot(gk)));
            e.v = onehot(gk);
            e.r = (gk == 0) ? model[3] : model[1];
            e.s = (gk == 0) ? model[1] : model[3];
            sb.push_back(e);
            @(negedge clk);
        end
        req_valid = 2'b00;
        repeat (3) @(negedge clk);

        // RMW through the 3-cycle adder
        issue(0, 2'b01, 3'd1, 3'd0, 3'd0, 16'd5, 1'b1);
        repeat (2) @(negedge clk);
        issue(0, 2'b01, 3'd2, 3'd0, 3'd0, 16'd7, 1'b1);
        repeat (2) @(negedge clk);
        issue(0, 2'b10, 3'd4, 3'd1, 3'd2, 16'h0, 1'b1);
        chk("rmw_radr", {rf_r_adr, rf_s_adr}, {26'd0, 3'd1, 3'd2});
        @(negedge clk);
        chk("rmw_ops", {alu_a, alu_b}, {16'd5, 16'd7});
        chk("rmw_we_t2", 32'(rf_we), 32'd0);
        @(negedge clk);
        chk("rmw_we_t3", 32'(rf_we), 32'd0);
        @(negedge clk);
        chk("rmw_we_t4", {rf_we, rf_w_adr}, {28'd0, 1'b1, 3'd4});
        chk("rmw_w_t4", 32'(rf_w), 32'd12);
        @(negedge clk);
        chk("rmw_rsp_t5", 32'(rsp_valid), 32'b01);
        @(negedge clk);
        issue(1, 2'b00, 3'd0, 3'd4, 3'd1, 16'h0, 1'b1);
        repeat (2) @(negedge clk);

        // Clear beats a pending request
        clr_req = 1'b1;
        req_op[1:0] = 2'b01; req_wadr[2:0] = 3'd5; req_wdata[15:0] = 16'hAAAA;
        req_valid[0] = 1'b1;
        #1;
        chk("clr_block_ready", 32'(req_ready), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) clr_req = 1'b0;
            chk("clr_busy", {clr_busy, rf_we}, 32'b11);
            chk("clr_adr", 32'(rf_w_adr), 32'(k));
            chk("clr_w", 32'(rf_w), 32'd0);
            chk("clr_ready", 32'(req_ready), 32'd0);
        end
        for (int i = 0; i < 8; i++) model[i] = '0;
        @(negedge clk);
        chk("clr_done", {clr_busy, rf_we}, 32'd0);
        issue(0, 2'b01, 3'd5, 3'd0, 3'd0, 16'hAAAA, 1'b1);
        repeat (2) @(negedge clk);
        issue(1, 2'b00, 3'd0, 3'd1, 3'd2, 16'h0, 1'b1);
        repeat (2) @(negedge clk);
        issue(0, 2'b00, 3'd0, 3'd4, 3'd3, 16'h0, 1'b1);
        repeat (2) @(negedge clk);

        // Reset during RMW WAIT abandons the access
        issue(0, 2'b10, 3'd6, 3'd5, 3'd5, 16'h0, 1'b0);
        @(negedge clk);
        chk("pre_rst_ops", 32'(alu_a), 32'hAAAA);
        reset = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        req_op = 4'b0000;
        req_radr = {3'd3, 3'd6};
        req_sadr = {3'd3, 3'd5};
        req_valid = 2'b11;
        #1;
        chk("post_rst_tie", 32'(req_ready), 32'b01);
        e.v = 2'b01; e.r = model[6]; e.s = model[5];
        sb.push_back(e);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
